// File: rtl/fp_add_pipe_if.sv
// Handshake and data bundle between an operand producer, fp_add_pipe and the
// result consumer.
interface fp_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result_o;
    logic [2:0]   flags_o;

    modport slave (
        input  in_valid, a_i, b_i, sub_i, out_ready,
        output in_ready, out_valid, result_o, flags_o
    );

    modport master (
        output in_valid, a_i, b_i, sub_i, out_ready,
        input  in_ready, out_valid, result_o, flags_o
    );
endinterface

// File: rtl/fp_add_pipe.sv
// Three-stage elastic FP add/sub: align, add/sub, normalise+round (RNE).
// Subnormals flush to zero; NaN/Inf bypass the datapath with status flags.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_add_pipe_if.slave  bus
);
    localparam int W      = EXP_W + MAN_W + 1;
    localparam int SW     = MAN_W + 4;
    localparam int STAGES = 3;
    localparam int LZW    = $clog2(SW + 1);
    localparam int XW     = ((EXP_W > LZW) ? EXP_W : LZW) + 2;
    localparam logic [EXP_W-1:0]     EMAX   = '1;
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic             zsign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sigx;
        logic [SW-1:0]    sigy;
        logic             exc;
        logic [W-1:0]     exc_res;
        logic [2:0]       exc_flags;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic             zsign;
        logic [EXP_W-1:0] exp;
        logic [SW:0]      sum;
        logic             exc;
        logic [W-1:0]     exc_res;
        logic [2:0]       exc_flags;
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] ld;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic [W-1:0] res_d, res_q;
    logic [2:0]   flg_d, flg_q;

    // A stage may load when it is empty or its content moves on this cycle.
    assign ld[3] = !vld_pipe[3] || bus.out_ready;
    assign ld[2] = !vld_pipe[2] || ld[3];
    assign ld[1] = !vld_pipe[1] || ld[2];

    assign bus.in_ready  = ld[1];
    assign bus.out_valid = vld_pipe[3];
    assign bus.result_o  = res_q;
    assign bus.flags_o   = flg_q;

    // ---------------- stage 1: classify, swap, align ----------------
    logic             a_s, b_s, x_s, y_s;
    logic [EXP_W-1:0] a_e, b_e, x_e, y_e, d;
    logic [MAN_W-1:0] a_m, b_m, x_m, y_m;
    logic             a_nan, b_nan, a_inf, b_inf, swap;
    logic [SW-1:0]    sigx, sigy, sh;

    always_comb begin
        a_s = bus.a_i[W-1];
        b_s = bus.b_i[W-1] ^ bus.sub_i;
        a_e = bus.a_i[W-2:MAN_W];
        b_e = bus.b_i[W-2:MAN_W];
        a_m = (a_e == '0) ? '0 : bus.a_i[MAN_W-1:0];
        b_m = (b_e == '0) ? '0 : bus.b_i[MAN_W-1:0];
        a_nan = (a_e == EMAX) && (a_m != '0);
        b_nan = (b_e == EMAX) && (b_m != '0);
        a_inf = (a_e == EMAX) && (a_m == '0);
        b_inf = (b_e == EMAX) && (b_m == '0);

        swap = {b_e, b_m} > {a_e, a_m};
        {x_s, x_e, x_m} = swap ? {b_s, b_e, b_m} : {a_s, a_e, a_m};
        {y_s, y_e, y_m} = swap ? {a_s, a_e, a_m} : {b_s, b_e, b_m};

        d    = x_e - y_e;
        sigx = {(x_e != '0), x_m, 3'b000};
        sigy = {(y_e != '0), y_m, 3'b000};
        // Anything shifted past bit 0 collapses into the sticky bit.
        sh   = sigy >> d;

        s1_d.sign    = x_s;
        s1_d.zsign   = x_s & y_s;
        s1_d.eff_sub = x_s ^ y_s;
        s1_d.exp     = x_e;
        s1_d.sigx    = sigx;
        s1_d.sigy    = {sh[SW-1:1], sh[0] | (|(sigy & ~({SW{1'b1}} << d)))};

        s1_d.exc = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
            s1_d.exc_res   = QNAN;
            s1_d.exc_flags = 3'b100;
        end else begin
            s1_d.exc_res   = {(a_inf ? a_s : b_s), EMAX, {MAN_W{1'b0}}};
            s1_d.exc_flags = 3'b000;
        end
    end

    // ---------------- stage 2: magnitude add/sub ----------------
    always_comb begin
        s2_d.sign      = s1_q.sign;
        s2_d.zsign     = s1_q.zsign;
        s2_d.exp       = s1_q.exp;
        s2_d.sum       = s1_q.eff_sub ? ({1'b0, s1_q.sigx} - {1'b0, s1_q.sigy})
                                      : ({1'b0, s1_q.sigx} + {1'b0, s1_q.sigy});
        s2_d.exc       = s1_q.exc;
        s2_d.exc_res   = s1_q.exc_res;
        s2_d.exc_flags = s1_q.exc_flags;
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic                    carry, rnd;
    logic [LZW-1:0]          lz;
    logic [SW-1:0]           n;
    logic signed [XW-1:0]    e_n, e_r;
    logic [MAN_W+1:0]        m;
    logic [MAN_W-1:0]        frac;

    always_comb begin
        lz = '0;
        for (int i = 0; i < SW; i++)
            if (s2_q.sum[i]) lz = LZW'(SW - 1 - i);

        carry = s2_q.sum[SW];
        n     = carry ? {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]} : (s2_q.sum[SW-1:0] << lz);
        e_n   = XW'(s2_q.exp) + XW'(carry) - XW'(lz);

        rnd  = n[2] & (n[1] | n[0] | n[3]);
        m    = {1'b0, n[SW-1:3]} + (MAN_W+2)'(rnd);
        e_r  = e_n + XW'(m[MAN_W+1]);
        frac = m[MAN_W+1] ? m[MAN_W:1] : m[MAN_W-1:0];

        if (s2_q.exc) begin
            res_d = s2_q.exc_res;
            flg_d = s2_q.exc_flags;
        end else if (s2_q.sum == '0) begin
            res_d = {s2_q.zsign, {(W-1){1'b0}}};
            flg_d = 3'b000;
        end else if (e_n <= 0) begin
            res_d = {s2_q.sign, {(W-1){1'b0}}};
            flg_d = 3'b001;
        end else if (e_r >= EMAX_X) begin
            res_d = {s2_q.sign, EMAX, {MAN_W{1'b0}}};
            flg_d = 3'b010;
        end else begin
            res_d = {s2_q.sign, e_r[EXP_W-1:0], frac};
            flg_d = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            res_q    <= '0;
            flg_q    <= '0;
        end else begin
            if (ld[1]) vld_pipe[1] <= bus.in_valid;
            if (ld[2]) vld_pipe[2] <= vld_pipe[1];
            if (ld[3]) vld_pipe[3] <= vld_pipe[2];
            if (ld[1] && bus.in_valid) s1_q <= s1_d;
            if (ld[2] && vld_pipe[1])  s2_q <= s2_d;
            if (ld[3] && vld_pipe[2]) begin
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: binary32 instance plus a binary16 instance.
module tb_fp_add_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus();
    fp_add_pipe_if #(.EXP_W(5), .MAN_W(10)) bus_h();

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    exp_t        e_pop;
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, n_acc = 0, n_out = 0, n_stale = 0;
    int          acc_base, out_base;
    logic [31:0] pend_res;
    logic [2:0]  pend_flg;
    bit          lat_on;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are decided by values that are stable from mid-cycle to the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{pend_res, pend_flg, cyc, lat_on});
                n_acc++;
            end
            if (bus.out_valid) begin
                if (q.size() == 0)
                    chk("spurious_out", bus.out_valid, 0);
                else if (!bus.out_ready)
                    chk("stall_hold", bus.result_o, q[0].res);
                else begin
                    e_pop = q.pop_front();
                    chk("result", bus.result_o, e_pop.res);
                    chk("flags", bus.flags_o, e_pop.flg);
                    if (e_pop.lat) chk("latency", cyc - e_pop.cyc, 3);
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic [2:0] ef);
        bit done;
        done = 0;
        bus.a_i = a; bus.b_i = b; bus.sub_i = s;
        pend_res = er; pend_flg = ef;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout", done, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.a_i = 0; bus.b_i = 0; bus.sub_i = 0; bus.out_ready = 1;
        bus_h.in_valid = 0; bus_h.a_i = 0; bus_h.b_i = 0; bus_h.sub_i = 0; bus_h.out_ready = 1;
        pend_res = 0; pend_flg = 0; lat_on = 1;

        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result_o, 0);
        chk("rst_flags", bus.flags_o, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back stream, no stalls
        send(32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'b000);
        send(32'h3F800000, 32'h40000000, 1, 32'hBF800000, 3'b000);
        send(32'h3F800000, 32'h3F800000, 1, 32'h00000000, 3'b000);
        send(32'h80000000, 32'h80000000, 0, 32'h80000000, 3'b000);
        send(32'h3F800000, 32'h33800000, 0, 32'h3F800000, 3'b000);
        send(32'h3F800001, 32'h33800000, 0, 32'h3F800002, 3'b000);
        send(32'h3F800000, 32'h33800001, 0, 32'h3F800001, 3'b000);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'b010);
        send(32'h7F800000, 32'hFF800000, 0, 32'h7FC00000, 3'b100);
        send(32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 3'b100);
        send(32'h00800000, 32'h00400000, 1, 32'h00800000, 3'b000);
        send(32'h00800001, 32'h00800000, 1, 32'h00000000, 3'b001);
        send(32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 3'b000);
        send(32'hFF800000, 32'hFF800000, 1, 32'h7FC00000, 3'b100);
        send(32'h3FC00000, 32'h3FA00000, 1, 32'h3E800000, 3'b000);
        drain();

        // backpressure: five ops against a stalled sink
        lat_on = 0;
        bus.out_ready = 0;
        acc_base = n_acc; out_base = n_out;
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 3'b000);
                send(32'h40000000, 32'h40000000, 0, 32'h40800000, 3'b000);
                send(32'h40400000, 32'h3F800000, 0, 32'h40800000, 3'b000);
                send(32'h40800000, 32'h3F800000, 1, 32'h40400000, 3'b000);
                send(32'h41200000, 32'h40A00000, 0, 32'h41700000, 3'b000);
            end
        join_none
        repeat (8) @(negedge clk);
        chk("bp_accepted", n_acc - acc_base, 3);
        chk("bp_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.out_ready = 1;
        wait fork;
        drain();
        chk("bp_outputs", n_out - out_base, 5);

        // asynchronous reset with three ops in flight
        bus.out_ready = 0;
        send(32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'b000);
        send(32'h40000000, 32'h40000000, 0, 32'h40800000, 3'b000);
        send(32'h3F800000, 32'h3F800000, 1, 32'h00000000, 3'b000);
        chk("fill_out_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", bus.out_valid, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_out_valid", bus.out_valid, 0);
        bus.out_ready = 1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) n_stale++;
        end
        chk("stale_results", n_stale, 0);

        // half-precision instance
        @(posedge clk); #1;
        bus_h.a_i = 16'h3C00; bus_h.b_i = 16'h4000; bus_h.sub_i = 0; bus_h.in_valid = 1;
        begin
            bit acc, got;
            acc = 0; got = 0;
            for (int k = 0; k < 50 && !acc; k++) begin
                @(negedge clk);
                acc = bus_h.in_ready;
                @(posedge clk); #1;
            end
            bus_h.in_valid = 0;
            chk("h_accept", acc, 1);
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk);
                got = bus_h.out_valid;
                if (!got) @(posedge clk);
            end
            chk("h_out_valid", got, 1);
            chk("h_result", bus_h.result_o, 16'h4200);
            chk("h_flags", bus_h.flags_o, 3'b000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point add/subtract unit for the systolic-array accumulate path; successor to the combinational adder.
- Adds configurable format widths, a per-operation add/sub select, round-to-nearest-even, exception handling with status flags, and a valid/ready elastic pipeline with backpressure.
- Three register stages: align, add/sub, normalise+round.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa width (hidden bit excluded)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  unit can accept an operand pair this cycle
a_i  in  EXP_W+MAN_W+1  operand A {sign, exp, man}
b_i  in  EXP_W+MAN_W+1  operand B
sub_i  in  1  0: A+B, 1: A-B (B sign inverted at stage 1)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result_o  out  EXP_W+MAN_W+1  rounded sum
flags_o  out  3  {invalid, overflow, underflow} for result_o

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, out_valid = 0, result_o = 0, flags_o = 0. An asynchronous reset mid-operation discards all in-flight data. No output pulse on release.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - Stage k advances when stage k+1 is empty or advancing. in_ready = !v1 || adv1 (combinational from out_ready through the chain).
  - result_o and flags_o are held stable while out_valid && !out_ready.
  - Latency: exactly 3 cycles from accept to out_valid with no stall. Throughput 1 op/cycle.
- Stage 1 (align):
  - Effective B sign = b.sign ^ sub_i.
  - Swap so the larger-magnitude operand is X; compare on {exp, man}.
  - Hidden bit = 1 if exp != 0. Subnormal inputs (exp = 0) are flushed to signed zero.
  - Shift Y significand right by expX - expY into an MAN_W+4-bit field with guard, round and sticky bits. Shifts >= MAN_W+3 leave only sticky.
  - Classify NaN/Inf.
- Stage 2 (add/sub):
  - Same effective signs: add. Different signs: subtract, smaller from larger; the result is never negative.
  - Result sign = X sign.
  - Exact zero result: +0, except (-0)+(-0) = -0.
- Stage 3 (normalise + round):
  - Carry-out: shift right 1 and increment the exponent; sticky ORs in the shifted bit.
  - Otherwise use a leading-zero count to shift left and decrement the exponent.
  - Round to nearest, ties to even. A rounding carry renormalises and increments the exponent.
  - Exponent >= all-ones: result = signed infinity, overflow = 1.
  - Exponent <= 0 after normalisation: result = signed zero, underflow = 1 (flush-to-zero).
- Exceptions (override the arithmetic path):
  - Any NaN input: canonical quiet NaN {0, all-ones, 1 followed by zeros}, invalid = 1.
  - Inf + (-Inf) after sub_i is applied: canonical NaN, invalid = 1.
  - Otherwise any Inf input gives that signed Inf, with flags = 0.
- Simultaneous in and out transfers in the same cycle are legal, and no data is lost or duplicated.

Test Plan:
- Basic add: 0x3F800000 + 0x40000000, sub_i=0, out_ready=1 -> 0x40400000 three cycles after accept, flags 000. Same operands with sub_i=1 -> 0xBF800000.
- Cancellation and zero sign: 0x3F800000 - 0x3F800000 -> 0x00000000. 0x80000000 + 0x80000000 -> 0x80000000.
- Ties-to-even rounding:
  - 0x3F800000 + 0x33800000 -> 0x3F800000.
  - 0x3F800001 + 0x33800000 -> 0x3F800002.
  - 0x3F800000 + 0x33800001 -> 0x3F800001.
- Exceptions:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 010.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags 100.
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000, flags 100.
  - 0x00800000 - 0x00400000 -> flushed to 0x00800000; 0x00800001 - 0x00800000 -> 0x00000000, flags 001.
- Backpressure: out_ready=0 with in_valid held high on 5 distinct ops -> exactly 3 accepted, then in_ready=0. Raise out_ready -> all 5 results emerge in order with no drops or duplicates; result_o is stable while stalled.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately and in_ready=1 after release. No stale results appear afterwards. Regression with EXP_W=5, MAN_W=10: 0x3C00 + 0x4000 -> 0x4200.
